id_stage: RTL and testbench
===========================

# id_stage

Instruction decode stage of the five-stage pipeline, directly downstream of instruction fetch. It registers the fetched address/instruction pair (IF/ID latch), reads the 32×32 register file, sign-extends the immediate, and resolves BEQ/BNE in-stage. It drives the branch select/target back to fetch and presents a registered ID/EX bundle to execute. Write-back enters through a dedicated write port.

## Interface
- No parameters; widths are fixed at 32-bit data and 5-bit register indices.
- i_clock  in  1  single clock, all state updates on rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_address  in  32  PC of the fetched instruction (from fetch o_address)
- i_instruccion  in  32  fetched instruction word
- i_stall  in  1  hazard stall: hold IF/ID, inject bubble into ID/EX
- i_flush  in  1  squash both IF/ID and ID/EX contents
- i_wb_write  in  1  register file write enable
- i_wb_reg  in  5  write index
- i_wb_data  in  32  write data
- o_select  out  1  branch taken, to fetch i_select (combinational)
- o_branch_address  out  32  branch target, to fetch i_branch_address (combinational)
- o_valid  out  1  ID/EX bundle holds a real instruction
- o_address  out  32  ID/EX: instruction PC
- o_opcode  out  6  ID/EX: instr[31:26]
- o_funct  out  6  ID/EX: instr[5:0]
- o_rs, o_rt, o_rd  out  5 each  ID/EX: instr[25:21], [20:16], [15:11]
- o_rs_data, o_rt_data  out  32 each  ID/EX: register operands
- o_imm  out  32  ID/EX: sign-extended instr[15:0]

## Operation
- IF/ID latch: {if_address, if_instr, if_valid}. Priority per edge: i_flush > internal squash > i_stall > load.
  - flush or squash: load instr 0x00000000, valid 0, address 0.
  - stall: hold.
  - otherwise: load i_address, i_instruccion, valid 1.
- Register file: 32×32. Register 0 reads as 0; writes to it are ignored. Write on rising edge when i_wb_write=1.
- Read bypass: when i_wb_write=1, i_wb_reg≠0, and i_wb_reg matches the rs or rt index being read, the read returns i_wb_data the same cycle.
- Immediate: imm = {{16{if_instr[15]}}, if_instr[15:0]}.
- Branch: BEQ opcode 6'b000100 taken if rs_data==rt_data; BNE 6'b000101 taken if not equal. Compare uses bypassed operands.
- o_select = if_valid & ~i_stall & ~i_flush & taken.
- o_branch_address = if_address + 4 + (imm << 2), modulo 2^32 (wrap ignored). Always driven, and meaningful only when o_select=1.
- Internal squash: when o_select=1, the next edge loads a bubble into IF/ID, discarding the sequential fetch. There is no delay slot.
- ID/EX register, priority per edge: i_flush or i_stall → all fields 0, o_valid 0. Otherwise capture the decoded fields with o_valid=if_valid.
- A taken branch still propagates to ID/EX with o_valid=1.

## Timing
- Reset (i_reset=0, async): all IF/ID, ID/EX and register file contents go to 0. o_valid=0, o_select=0, o_branch_address=4.
- On release, the first edge loads IF/ID. Reset mid-operation discards all in-flight instructions immediately.
- Latency: an instruction present at edge N is in IF/ID after N. Its ID/EX outputs are valid after edge N+1.
- o_select and o_branch_address change in the cycle after edge N, so fetch redirects at edge N+1.
- Write-back at edge M updates the array at M. A same-cycle read before M sees the data through the bypass.
- Stall held for k cycles: IF/ID holds and k bubbles enter ID/EX. The held instruction issues on the first unstalled edge.
- i_flush and i_stall together: flush wins.
- A branch under stall does not redirect until the stall drops.

## Test plan
- Reset: drive i_reset=0 mid-run with valid instructions in flight → all outputs 0 immediately, o_valid=0, o_branch_address=4; after release, reads of r1..r31 return 0.
- Write/bypass: write r5=0xDEADBEEF while decoding instr with rs=5 → same-cycle o_rs_data after next edge = 0xDEADBEEF; write r0=0x1234 → reads r0=0.
- BEQ taken: r1=r2=7, i_address=0x100, instr BEQ r1,r2,imm=0xFFFE → o_select=1, o_branch_address=0x0FC; next IF/ID holds bubble, ID/EX shows BEQ with o_valid=1, then the bubble.
- BNE not taken: r1=r2=7, BNE → o_select=0 and the following sequential instruction is decoded normally.
- Stall: assert i_stall for 2 cycles on an ADD at 0x200 → o_valid=0 for 2 cycles, then ADD with o_address=0x200, o_valid=1; the IF/ID instruction is unchanged throughout.
- Flush priority: i_flush=1 and i_stall=1 with a taken BEQ in IF/ID → o_select=0, both stages bubble, and fetch is not redirected.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID latch, 32x32 register file with write-back
// bypass, immediate sign extension, in-stage BEQ/BNE resolution, ID/EX register.
module id_stage (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_address,
    input  logic [31:0] i_instruccion,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_wb_write,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_data,
    output logic        o_select,
    output logic [31:0] o_branch_address,
    output logic        o_valid,
    output logic [31:0] o_address,
    output logic [5:0]  o_opcode,
    output logic [5:0]  o_funct,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    output logic [31:0] o_imm
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE = 6'b000101;

    // IF/ID latch
    logic [DATA_W-1:0] if_address_q, if_address_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic              if_valid_q, if_valid_d;

    // Register file
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];

    // ID/EX register
    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_address_q, ex_address_d;
    logic [OP_W-1:0]   ex_opcode_q, ex_opcode_d;
    logic [OP_W-1:0]   ex_funct_q, ex_funct_d;
    logic [REG_W-1:0]  ex_rs_q, ex_rs_d;
    logic [REG_W-1:0]  ex_rt_q, ex_rt_d;
    logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;

    // Decode signals
    logic [OP_W-1:0]   opcode_c;
    logic [REG_W-1:0]  rs_idx_c;
    logic [REG_W-1:0]  rt_idx_c;
    logic [DATA_W-1:0] rs_data_c;
    logic [DATA_W-1:0] rt_data_c;
    logic [DATA_W-1:0] imm_c;
    logic              taken_c;
    logic              wb_live_c;
    logic              squash_c;

    // Field extraction, bypassed operand read, immediate and branch resolution
    always_comb begin
        opcode_c  = if_instr_q[31:26];
        rs_idx_c  = if_instr_q[25:21];
        rt_idx_c  = if_instr_q[20:16];
        imm_c     = {{16{if_instr_q[15]}}, if_instr_q[15:0]};
        wb_live_c = i_wb_write && (i_wb_reg != REG_W'(0));
        rs_data_c = (wb_live_c && (i_wb_reg == rs_idx_c)) ? i_wb_data : rf_q[rs_idx_c];
        rt_data_c = (wb_live_c && (i_wb_reg == rt_idx_c)) ? i_wb_data : rf_q[rt_idx_c];
        taken_c   = 1'b0;
        if (opcode_c == OP_BEQ) taken_c = (rs_data_c == rt_data_c);
        if (opcode_c == OP_BNE) taken_c = (rs_data_c != rt_data_c);
        o_select         = if_valid_q && !i_stall && !i_flush && taken_c;
        o_branch_address = if_address_q + DATA_W'(4) + {imm_c[DATA_W-3:0], 2'b00};
        squash_c         = o_select;
    end

    // IF/ID next state: flush > squash > stall > load
    always_comb begin
        if_address_d = if_address_q;
        if_instr_d   = if_instr_q;
        if_valid_d   = if_valid_q;
        if (i_flush || squash_c) begin
            if_address_d = '0;
            if_instr_d   = '0;
            if_valid_d   = 1'b0;
        end else if (!i_stall) begin
            if_address_d = i_address;
            if_instr_d   = i_instruccion;
            if_valid_d   = 1'b1;
        end
    end

    // Register file write; r0 is never written so it always reads zero
    always_comb begin
        rf_d = rf_q;
        if (wb_live_c) rf_d[i_wb_reg] = i_wb_data;
    end

    // ID/EX next state: flush or stall inserts a bubble
    always_comb begin
        ex_valid_d   = 1'b0;
        ex_address_d = '0;
        ex_opcode_d  = '0;
        ex_funct_d   = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_rd_d      = '0;
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        if (!i_flush && !i_stall) begin
            ex_valid_d   = if_valid_q;
            ex_address_d = if_address_q;
            ex_opcode_d  = opcode_c;
            ex_funct_d   = if_instr_q[5:0];
            ex_rs_d      = rs_idx_c;
            ex_rt_d      = rt_idx_c;
            ex_rd_d      = if_instr_q[15:11];
            ex_rs_data_d = rs_data_c;
            ex_rt_data_d = rt_data_c;
            ex_imm_d     = imm_c;
        end
    end

    // State registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            if_address_q <= '0;
            if_instr_q   <= '0;
            if_valid_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
            ex_valid_q   <= 1'b0;
            ex_address_q <= '0;
            ex_opcode_q  <= '0;
            ex_funct_q   <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
        end else begin
            if_address_q <= if_address_d;
            if_instr_q   <= if_instr_d;
            if_valid_q   <= if_valid_d;
            rf_q         <= rf_d;
            ex_valid_q   <= ex_valid_d;
            ex_address_q <= ex_address_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_funct_q   <= ex_funct_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
        end
    end

    assign o_valid   = ex_valid_q;
    assign o_address = ex_address_q;
    assign o_opcode  = ex_opcode_q;
    assign o_funct   = ex_funct_q;
    assign o_rs      = ex_rs_q;
    assign o_rt      = ex_rt_q;
    assign o_rd      = ex_rd_q;
    assign o_rs_data = ex_rs_data_q;
    assign o_rt_data = ex_rt_data_q;
    assign o_imm     = ex_imm_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, write/bypass, BEQ/BNE, stall, flush.
module tb_id_stage;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] i_address;
    logic [31:0] i_instruccion;
    logic        i_stall;
    logic        i_flush;
    logic        i_wb_write;
    logic [4:0]  i_wb_reg;
    logic [31:0] i_wb_data;
    logic        o_select;
    logic [31:0] o_branch_address;
    logic        o_valid;
    logic [31:0] o_address;
    logic [5:0]  o_opcode;
    logic [5:0]  o_funct;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_imm;

    int checks = 0;
    int errors = 0;

    // Hand-encoded instructions
    localparam logic [31:0] ADD_R3_R0_R0 = 32'h0000_1820;
    localparam logic [31:0] ADD_R4_R5_R0 = 32'h00A0_2020;
    localparam logic [31:0] ADD_R7       = 32'h0000_3820;
    localparam logic [31:0] ADD_R8       = 32'h0000_4020;
    localparam logic [31:0] ADD_R9_R1_R2 = 32'h0022_4820;
    localparam logic [31:0] ADD_R9_R5_R1 = 32'h00A1_4820;
    localparam logic [31:0] BEQ_R1_R2_M2 = 32'h1022_FFFE;
    localparam logic [31:0] BNE_R1_R2_16 = 32'h1422_0010;

    id_stage dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_address        (i_address),
        .i_instruccion    (i_instruccion),
        .i_stall          (i_stall),
        .i_flush          (i_flush),
        .i_wb_write       (i_wb_write),
        .i_wb_reg         (i_wb_reg),
        .i_wb_data        (i_wb_data),
        .o_select         (o_select),
        .o_branch_address (o_branch_address),
        .o_valid          (o_valid),
        .o_address        (o_address),
        .o_opcode         (o_opcode),
        .o_funct          (o_funct),
        .o_rs             (o_rs),
        .o_rt             (o_rt),
        .o_rd             (o_rd),
        .o_rs_data        (o_rs_data),
        .o_rt_data        (o_rt_data),
        .o_imm            (o_imm)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Hard time limit so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_if(input logic [31:0] addr, input logic [31:0] instr);
        i_address     = addr;
        i_instruccion = instr;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        i_wb_write = we;
        i_wb_reg   = r;
        i_wb_data  = d;
    endtask

    initial begin
        i_reset = 1'b0;
        i_stall = 1'b0;
        i_flush = 1'b0;
        set_if(32'h0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);
        #2;
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_select", 32'(o_select), 32'd0);
        chk("reset_baddr", o_branch_address, 32'h4);
        chk("reset_address", o_address, 32'h0);

        // Release; first edge loads ADD r3,r0,r0 while r0 write is attempted
        set_if(32'h10, ADD_R3_R0_R0);
        set_wb(1'b1, 5'd0, 32'h1234);
        #1 i_reset = 1'b1;
        tick();

        set_wb(1'b1, 5'd1, 32'd7);
        set_if(32'h14, ADD_R4_R5_R0);
        tick();
        chk("add_valid", 32'(o_valid), 32'd1);
        chk("add_address", o_address, 32'h10);
        chk("add_rd", 32'(o_rd), 32'd3);
        chk("add_funct", 32'(o_funct), 32'h20);
        chk("r0_read_zero", o_rs_data, 32'h0);

        // Write r5 while instruction with rs=5 sits in IF/ID
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        set_if(32'h18, 32'h0);
        tick();
        chk("bypass_rs", 32'(o_rs), 32'd5);
        chk("bypass_rs_data", o_rs_data, 32'hDEAD_BEEF);
        chk("bypass_address", o_address, 32'h14);

        set_wb(1'b1, 5'd2, 32'd7);
        set_if(32'h100, BEQ_R1_R2_M2);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        set_if(32'h104, ADD_R7);
        #1;
        chk("beq_select", 32'(o_select), 32'd1);
        chk("beq_target", o_branch_address, 32'h0FC);
        tick();
        chk("beq_ex_valid", 32'(o_valid), 32'd1);
        chk("beq_ex_opcode", 32'(o_opcode), 32'h4);
        chk("beq_ex_address", o_address, 32'h100);
        chk("beq_ex_imm", o_imm, 32'hFFFF_FFFE);
        chk("squash_select", 32'(o_select), 32'd0);
        chk("squash_baddr", o_branch_address, 32'h4);

        set_if(32'h0FC, ADD_R7);
        tick();
        chk("bubble_valid", 32'(o_valid), 32'd0);
        chk("bubble_address", o_address, 32'h0);

        // BNE with equal operands: not taken, fall-through decodes normally
        set_if(32'h100, BNE_R1_R2_16);
        tick();
        chk("add7_address", o_address, 32'h0FC);
        chk("add7_valid", 32'(o_valid), 32'd1);
        set_if(32'h104, ADD_R8);
        #1;
        chk("bne_select", 32'(o_select), 32'd0);
        tick();
        chk("bne_ex_opcode", 32'(o_opcode), 32'h5);
        chk("bne_ex_valid", 32'(o_valid), 32'd1);
        set_if(32'h200, ADD_R9_R1_R2);
        tick();
        chk("seq_address", o_address, 32'h104);
        chk("seq_valid", 32'(o_valid), 32'd1);
        chk("seq_rd", 32'(o_rd), 32'd8);

        // Two-cycle stall on ADD r9 @0x200
        i_stall = 1'b1;
        set_if(32'h204, 32'h1111_1111);
        tick();
        chk("stall1_valid", 32'(o_valid), 32'd0);
        chk("stall1_hold", o_branch_address, 32'h0001_2284);
        tick();
        chk("stall2_valid", 32'(o_valid), 32'd0);
        chk("stall2_hold", o_branch_address, 32'h0001_2284);
        i_stall = 1'b0;
        set_if(32'h204, 32'h0);
        tick();
        chk("unstall_valid", 32'(o_valid), 32'd1);
        chk("unstall_address", o_address, 32'h200);
        chk("unstall_rs_data", o_rs_data, 32'd7);
        chk("unstall_rt_data", o_rt_data, 32'd7);

        // Flush and stall together on a taken BEQ
        set_if(32'h100, BEQ_R1_R2_M2);
        tick();
        chk("pre_flush_select", 32'(o_select), 32'd1);
        i_flush = 1'b1;
        i_stall = 1'b1;
        set_if(32'h500, ADD_R7);
        #1;
        chk("flush_select", 32'(o_select), 32'd0);
        tick();
        chk("flush_ex_valid", 32'(o_valid), 32'd0);
        i_flush = 1'b0;
        i_stall = 1'b0;
        set_if(32'h600, ADD_R8);
        #1;
        chk("flush_if_select", 32'(o_select), 32'd0);
        chk("flush_if_baddr", o_branch_address, 32'h4);
        tick();
        chk("flush_bubble_valid", 32'(o_valid), 32'd0);
        chk("flush_bubble_addr", o_address, 32'h0);

        // Mid-run asynchronous reset with valid work in both stages
        set_if(32'h100, BEQ_R1_R2_M2);
        tick();
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        chk("pre_rst_select", 32'(o_select), 32'd1);
        #2 i_reset = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_select", 32'(o_select), 32'd0);
        chk("rst_baddr", o_branch_address, 32'h4);
        chk("rst_address", o_address, 32'h0);
        chk("rst_rs_data", o_rs_data, 32'h0);
        #2 i_reset = 1'b1;
        set_if(32'h200, ADD_R9_R5_R1);
        tick();
        tick();
        chk("post_rst_r5", o_rs_data, 32'h0);
        chk("post_rst_r1", o_rt_data, 32'h0);
        chk("post_rst_valid", 32'(o_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
